period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous square wave, such as a clock-divider output or an external pulse source, in units of `clk` cycles.
- It is the receiving end for the divided-clock/blink signals the team generates. It lets hardware or a 7-segment display path read back and check divider ratios.
- Results are registered and flagged with a one-cycle `valid` strobe. A timeout flags a stalled input.

---
 rtl/period_meter.sv | 163 ++++++++++++++++
 tb/tb_period_meter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow asynchronous square wave in clk cycles
module period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   s_dly_q, s_dly_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;

    logic             s;
    logic             s_ok;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_limit;

    // fill_q marks when s reflects sig_in again after reset, so an input
    // that is already high at release cannot pass WAIT_LOW early.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        s        = sync_q[SYNC_STAGES-1];
        s_ok     = fill_q[SYNC_STAGES-1];
        s_dly_d  = s;
        rise     = s & ~s_dly_q;
        fall     = ~s & s_dly_q;
        cnt_inc  = cnt_q + ONE_V;
        at_limit = (cnt_inc == TIMEOUT_V);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_tmp_d    = hi_tmp_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        if (!enable) begin
            state_d   = WAIT_LOW;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOW: begin
                    cnt_d = '0;
                    if (s_ok && !s) begin
                        state_d = WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d   = HIGH;
                        timeout_d = 1'b0;
                    end
                end
                HIGH: begin
                    // an edge on the limit cycle takes priority over the timeout
                    if (fall) begin
                        hi_tmp_d = cnt_inc;
                        cnt_d    = cnt_inc;
                        state_d  = LOW;
                    end else if (at_limit) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d    = cnt_inc;
                        high_time_d = hi_tmp_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = '0;
                        state_d     = HIGH;
                    end else if (at_limit) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '0;
            fill_q      <= '0;
            s_dly_q     <= 1'b0;
            state_q     <= WAIT_LOW;
            cnt_q       <= '0;
            hi_tmp_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            s_dly_q     <= s_dly_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_tmp_q    <= hi_tmp_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter with directed square-wave stimulus
module tb_period_meter;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic             enable = 1'b1;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    int exp_p[$];
    int exp_h[$];

    bit armed = 1'b0;
    int prev_hi = 0;
    int prev_lo = 0;

    period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (64),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .enable   (enable),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A rise completes the previous rise-fall-rise cycle when one is open.
    task automatic drive_rise();
        if (armed) begin
            exp_p.push_back(prev_hi + prev_lo);
            exp_h.push_back(prev_hi);
        end
        sig_in = 1'b1;
    endtask

    task automatic wave(input int hi, input int lo);
        drive_rise();
        step(hi);
        sig_in = 1'b0;
        step(lo);
        prev_hi = hi;
        prev_lo = lo;
        armed   = 1'b1;
    endtask

    task automatic monitor();
        logic prev_v;
        int   p;
        int   h;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) begin
                check("valid_single_cycle", {31'b0, prev_v}, 32'd0);
                if (exp_p.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid at %0t",
                             period, high_time, $time);
                end else begin
                    p = exp_p.pop_front();
                    h = exp_h.pop_front();
                    check("sb_period", period, p);
                    check("sb_high_time", high_time, h);
                end
            end
            prev_v = valid;
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        step(1);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_timeout", {31'b0, timeout}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        step(1);
        rst = 1'b1;
        step(5);

        // divider-style 5/5 wave
        drive_rise();
        step(2);
        check("t1_busy_before_rise", {31'b0, busy}, 0);
        step(1);
        check("t1_busy_at_rise", {31'b0, busy}, 1);
        step(2);
        sig_in = 1'b0;
        step(5);
        prev_hi = 5; prev_lo = 5; armed = 1'b1;
        repeat (4) wave(5, 5);
        check("t1_period", period, 10);
        check("t1_high_time", high_time, 5);

        // duty cycle 3/7
        repeat (4) wave(3, 7);
        check("t2_period", period, 10);
        check("t2_high_time", high_time, 3);

        // timeout: rise then held high
        drive_rise();
        step(66);
        check("t3_timeout_before_limit", {31'b0, timeout}, 0);
        step(1);
        check("t3_timeout_at_limit", {31'b0, timeout}, 1);
        check("t3_period_kept", period, 10);
        check("t3_high_kept", high_time, 3);
        check("t3_busy_idle", {31'b0, busy}, 0);
        sig_in = 1'b0;
        step(10);
        check("t3_timeout_sticky", {31'b0, timeout}, 1);
        armed = 1'b0;
        drive_rise();
        step(2);
        check("t3_timeout_before_rise", {31'b0, timeout}, 1);
        step(1);
        check("t3_timeout_cleared", {31'b0, timeout}, 0);
        check("t3_busy_resumed", {31'b0, busy}, 1);
        step(2);
        sig_in = 1'b0;
        step(5);
        prev_hi = 5; prev_lo = 5; armed = 1'b1;
        repeat (2) wave(5, 5);
        step(5);
        check("t3_queue_drained", exp_p.size(), 0);

        // high through reset, late fall, then 6/6 wave
        sig_in = 1'b1;
        rst    = 1'b0;
        armed  = 1'b0;
        step(2);
        rst = 1'b1;
        step(20);
        sig_in = 1'b0;
        step(6);
        repeat (4) wave(6, 6);
        check("t4_period", period, 12);
        check("t4_high_time", high_time, 6);

        // reset while in LOW
        drive_rise();
        step(5);
        sig_in = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("t5_period_cleared", period, 0);
        check("t5_high_cleared", high_time, 0);
        check("t5_valid_cleared", {31'b0, valid}, 0);
        check("t5_busy_cleared", {31'b0, busy}, 0);
        armed = 1'b0;
        step(3);
        repeat (3) wave(5, 5);
        check("t5_period", period, 10);

        // enable dropped mid-HIGH
        drive_rise();
        step(4);
        enable = 1'b0;
        step(4);
        check("t6_busy_gap", {31'b0, busy}, 0);
        check("t6_timeout_gap", {31'b0, timeout}, 0);
        check("t6_period_kept", period, 10);
        check("t6_high_kept", high_time, 5);
        enable = 1'b1;
        sig_in = 1'b0;
        armed  = 1'b0;
        step(5);
        repeat (3) wave(7, 4);
        check("t6_period", period, 11);
        check("t6_high_time", high_time, 7);

        step(5);
        check("final_queue_drained", exp_p.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
